spi_master_gen: RTL and testbench
=================================

# spi_master_gen

Parametrised SPI master for the tile's serial peripherals, the next generation of the single-byte, mode-0 SPI controller. It adds configurable word width, a programmable SCLK divider, all four SPI modes (CPOL/CPHA), run-time MSB/LSB-first order, several chip selects, and chip-select hold across back-to-back words. It sits between the core's load/store sequencer and the external SPI pins.

## Interface
Parameters:
- WIDTH, 8: bits per transfer word (≥2).
- NUM_SS, 1: number of active-low chip-select outputs (≥1).
- DIV_W, 8: width of the divider input.
- SS_W, derived: NUM_SS>1 ? $clog2(NUM_SS) : 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a transfer; accepted only when ready=1.
- hold_ss  in  1  keep the selected n_ss asserted after this word.
- ss_sel  in  SS_W  index of the chip select to assert.
- cpol  in  1  SCLK idle level.
- cpha  in  1  0 = sample on the leading edge; 1 = sample on the trailing edge.
- lsb_first  in  1  1 = shift LSB first.
- div  in  DIV_W  half-period = div+1 clk cycles.
- tx_word  in  WIDTH  data to send.
- ready  out  1  idle, can accept start.
- done  out  1  one-cycle pulse when the word completes.
- rx_word  out  WIDTH  received word, registered; stable until the next done.
- n_ss  out  NUM_SS  chip selects, active low.
- sclk  out  1  SPI clock.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in.

## Operation
- Accept cycle T0 is a rising edge with ready=1 and start=1. On T0 the block latches ss_sel, hold_ss, cpol, cpha, lsb_first, div and tx_word. Inputs are don't-care outside T0.
- start while ready=0 is ignored. It is not queued.
- States are IDLE, SETUP, SHIFT and HOLD. On accept the block goes IDLE→SETUP.
- SETUP lasts one half-period. Then SHIFT lasts 2×WIDTH half-periods, with one SCLK edge at the end of each. HOLD lasts one half-period. The block then returns to IDLE.
- From T0+1:
  - n_ss[ss_sel]=0.
  - sclk=cpol.
  - mosi = first bit (tx bit WIDTH-1, or bit 0 if lsb_first).
- Edges alternate leading (sclk→!cpol) and trailing (sclk→cpol). There are WIDTH of each.
- cpha=0:
  - Each leading edge samples miso.
  - Each trailing edge except the last drives the next bit on mosi.
- cpha=1:
  - Leading edge k drives bit k on mosi.
  - Each trailing edge samples miso.
- The sample register captures miso as seen in the clk cycle that creates the sampling edge.
- Received bits fill rx_word in the same order as transmission. With lsb_first=0 the first received bit lands in bit WIDTH-1.
- End of HOLD (IDLE entry):
  - rx_word updates.
  - done=1 for one cycle.
  - ready=1.
  - If hold_ss=0, all n_ss deassert on that cycle. If hold_ss=1, n_ss[ss_sel] stays low.
- A held select is released at the next accept if the new ss_sel differs. In that case the old select goes high and the new one goes low on the same cycle, T0+1. If ss_sel is unchanged it stays low throughout.
- ss_sel ≥ NUM_SS: the transfer runs normally with no n_ss asserted.
- The divider counter is DIV_W bits and counts div down to 0. div=all-ones gives a half-period of 2^DIV_W cycles with no overflow.

## Timing
- Reset values (asynchronous, immediate, also mid-transfer):
  - State IDLE.
  - n_ss all 1.
  - sclk=0, because the latched cpol resets to 0.
  - mosi=0.
  - ready=1.
  - done=0.
  - rx_word=0.
- A mid-transfer reset discards the partial word. No done pulse is generated.
- Let H=div+1:
  - Edge k (k=1..2×WIDTH) occurs at T0+1+k·H.
  - done and ready rise at T0+1+(2·WIDTH+1)·H.
  - ready is 0 from T0+1 until then.
- The earliest next accept is the done cycle itself (ready=1 and start=1 on that edge). Back-to-back words therefore have zero idle gap beyond HOLD.
- In IDLE, sclk holds the last latched cpol and mosi holds its last value.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Test plan
- Mode 0, div=0, WIDTH=8, miso tied to mosi, tx 0xA5:
  - rx_word=0xA5.
  - Exactly 8 rising sclk edges.
  - done at T0+18.
  - n_ss[0] high again at T0+18.
- Mode 3 (cpol=1, cpha=1), div=2, tx 0x3C, miso from a model returning 0xC3:
  - sclk idles high.
  - Half-period is 3 cycles.
  - rx_word=0xC3.
  - done at T0+52.
- lsb_first=1, mode 1, tx 0x01:
  - First mosi bit is 1, remaining bits 0.
  - A slave model sending 0x80 LSB-first gives rx_word=0x80.
- NUM_SS=4, hold_ss=1 with ss_sel=2, then a back-to-back start on the done cycle with hold_ss=0 and ss_sel=2:
  - n_ss[2] stays low continuously for both words and rises after the second done.
  - Repeat with second ss_sel=1: n_ss[2] rises and n_ss[1] falls at the same T0+1.
- start pulsed repeatedly while busy:
  - Ignored; exactly one done.
- rst_n low at T0+7:
  - Outputs go to reset values immediately.
  - No done pulse.
  - A new transfer after release completes normally.

Source files
------------

// File: rtl/spi_master_gen.sv
// spi_master_gen - parametrised SPI master (WIDTH-bit words, all four modes,
// programmable SCLK divider, MSB/LSB-first, NUM_SS chip selects with hold).
//
// Ports:
//   clk, rst_n      system clock (rising edge), asynchronous active-low reset
//   start, ready    transfer request, accepted only while ready=1
//   hold_ss, ss_sel keep select low after the word / which select to drive
//   cpol, cpha      SPI mode
//   lsb_first       bit order
//   div             SCLK half-period = div+1 clk cycles
//   tx_word         word to send (latched on accept)
//   done            one-cycle pulse at word completion
//   rx_word         received word, updated with done
//   n_ss            active-low chip selects
//   sclk, mosi      SPI clock and data out
//   miso            SPI data in
//
// Timeline after the accept edge T0 (H = div+1): SCLK edge k (1..2*WIDTH) is
// registered on edge T0+k*H and done on edge T0+(2*WIDTH+1)*H. SETUP covers
// the half-period ending with edge 1, SHIFT runs up to the last edge, HOLD is
// the final half-period before returning to IDLE.
module spi_master_gen #(
    parameter int WIDTH  = 8,
    parameter int NUM_SS = 1,
    parameter int DIV_W  = 8,
    parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold_ss,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  div,
    input  logic [WIDTH-1:0]  tx_word,
    output logic              ready,
    output logic              done,
    output logic [WIDTH-1:0]  rx_word,
    output logic [NUM_SS-1:0] n_ss,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam int EW = $clog2(2 * WIDTH + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * WIDTH);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t            state_reg;
    logic [DIV_W-1:0]  cnt_reg;
    logic [DIV_W-1:0]  div_reg;
    logic [EW-1:0]     edge_cnt_reg;   // SCLK edges already produced
    logic [WIDTH-1:0]  tx_reg;
    logic [WIDTH-1:0]  rx_sh_reg;
    logic              hold_reg;
    logic              cpha_reg;
    logic              lsb_reg;

    logic [NUM_SS-1:0] ss_dec;
    logic [EW-1:0]     edge_num;
    logic              half_end;
    logic              samp_edge;
    logic              drive_edge;
    logic              next_bit;

    // Active-low one-hot decode; an out-of-range ss_sel selects nothing.
    generate
        for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_ss_dec
            assign ss_dec[gi] = (ss_sel != SS_W'(gi));
        end
    endgenerate

    // Bit number idx of a word in transmission order.
    function automatic logic pick_bit(input logic [WIDTH-1:0] w,
                                      input logic lsb,
                                      input logic [EW-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx == EW'(i)) begin
                b = lsb ? w[i] : w[WIDTH-1-i];
            end
        end
        return b;
    endfunction

    assign edge_num  = edge_cnt_reg + EW'(1);
    assign half_end  = (cnt_reg == '0);
    // Odd edges are leading. cpha=0 samples on leading, cpha=1 on trailing.
    assign samp_edge = edge_num[0] ^ cpha_reg;
    // The non-sampling edge drives bit edge_num/2; for cpha=0 the final
    // trailing edge has no bit left to drive.
    assign drive_edge = !samp_edge && (edge_num != LAST_EDGE);
    assign next_bit   = pick_bit(tx_reg, lsb_reg, edge_num >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            div_reg      <= '0;
            edge_cnt_reg <= '0;
            tx_reg       <= '0;
            rx_sh_reg    <= '0;
            hold_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            lsb_reg      <= 1'b0;
            ready        <= 1'b1;
            done         <= 1'b0;
            rx_word      <= '0;
            n_ss         <= '1;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        div_reg      <= div;
                        cnt_reg      <= div;
                        cpha_reg     <= cpha;
                        lsb_reg      <= lsb_first;
                        hold_reg     <= hold_ss;
                        tx_reg       <= tx_word;
                        edge_cnt_reg <= '0;
                        // Replaces any held select in one step.
                        n_ss         <= ss_dec;
                        sclk         <= cpol;
                        mosi         <= pick_bit(tx_word, lsb_first, '0);
                        ready        <= 1'b0;
                        state_reg    <= SETUP;
                    end
                end
                default: begin
                    if (!half_end) begin
                        cnt_reg <= cnt_reg - DIV_W'(1);
                    end else begin
                        cnt_reg <= div_reg;
                        if (state_reg == HOLD) begin
                            state_reg <= IDLE;
                            rx_word   <= rx_sh_reg;
                            done      <= 1'b1;
                            ready     <= 1'b1;
                            if (!hold_reg) begin
                                n_ss <= '1;
                            end
                        end else begin
                            sclk         <= ~sclk;
                            edge_cnt_reg <= edge_num;
                            if (samp_edge) begin
                                // Fill in transmission order.
                                rx_sh_reg <= lsb_reg ? {miso, rx_sh_reg[WIDTH-1:1]}
                                                     : {rx_sh_reg[WIDTH-2:0], miso};
                            end
                            if (drive_edge) begin
                                mosi <= next_bit;
                            end
                            state_reg <= (edge_num == LAST_EDGE) ? HOLD : SHIFT;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_gen.sv
module tb_spi_master_gen;

    localparam int W   = 8;
    localparam int NSS = 4;
    localparam int DW  = 4;
    localparam int SW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic          hold_ss;
    logic [SW-1:0] ss_sel;
    logic          cpol;
    logic          cpha;
    logic          lsb_first;
    logic [DW-1:0] div;
    logic [W-1:0]  tx_word;
    logic          miso;
    logic          ready;
    logic          done;
    logic [W-1:0]  rx_word;
    logic [NSS-1:0] n_ss;
    logic          sclk;
    logic          mosi;

    int n_checks = 0;
    int n_fail   = 0;

    // Configuration of a word started on the done cycle of the previous one.
    logic [W-1:0]  nx_tx;
    logic [SW-1:0] nx_sel;
    logic          nx_hold;

    spi_master_gen #(.WIDTH(W), .NUM_SS(NSS), .DIV_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold_ss(hold_ss),
        .ss_sel(ss_sel), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .div(div), .tx_word(tx_word), .ready(ready), .done(done),
        .rx_word(rx_word), .n_ss(n_ss), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    // i-th bit on the wire for a word sent in the given order.
    function automatic logic bit_of(input logic [W-1:0] w, input logic lsb, input int i);
        return lsb ? w[i] : w[W-1-i];
    endfunction

    function automatic logic [NSS-1:0] sel_mask(input int sel);
        logic [NSS-1:0] m;
        m = '1;
        if (sel < NSS) m[sel] = 1'b0;
        return m;
    endfunction

    // One word: drives start (unless already issued), plays the slave,
    // times every SCLK edge and checks the result against the protocol rules.
    task automatic xfer(input string name, input logic [W-1:0] tx, input logic [W-1:0] slv,
                        input logic [DW-1:0] d, input logic pol, input logic pha,
                        input logic lsb, input logic hold, input logic [SW-1:0] sel,
                        input logic lb, input logic pre, input logic chain,
                        input logic busy_pulse);
        int h, d_exp, c, done_c, edges, lead, trail, nsamp, tim_err, busy_err;
        int idx, wait_c, extra_done, extra_err, ext;
        logic prev;
        logic [W-1:0] mo_bits, mo_exp, rx_exp;
        h = int'(d) + 1;
        d_exp = (2 * W + 1) * h;
        if (!pre) begin
            wait_c = 0;
            while (ready !== 1'b1 && wait_c < 1000) begin
                @(negedge clk);
                wait_c++;
            end
            n_checks++;
            if (ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s ready_wait got=%b want=1", name, ready);
            end
            tx_word = tx; div = d; cpol = pol; cpha = pha; lsb_first = lsb;
            hold_ss = hold; ss_sel = sel; start = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        // Inputs are don't-care after the accept edge.
        tx_word = W'($urandom); div = DW'($urandom); cpol = 1'($urandom);
        cpha = 1'($urandom); lsb_first = 1'($urandom); hold_ss = 1'($urandom);
        ss_sel = SW'($urandom);
        @(negedge clk);
        n_checks++;
        if (n_ss !== sel_mask(int'(sel)) || sclk !== pol || mosi !== bit_of(tx, lsb, 0) || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s first_cycle got n_ss=%b sclk=%b mosi=%b ready=%b want n_ss=%b sclk=%b mosi=%b ready=0",
                     name, n_ss, sclk, mosi, ready, sel_mask(int'(sel)), pol, bit_of(tx, lsb, 0));
        end
        prev = pol; edges = 0; lead = 0; trail = 0; nsamp = 0; mo_bits = '0;
        tim_err = 0; busy_err = 0; done_c = -1;
        miso = lb ? mosi : bit_of(slv, lsb, 0);
        for (c = 1; c <= d_exp + 20; c++) begin
            @(negedge clk);
            if (sclk !== prev) begin
                edges++;
                if (c != edges * h) tim_err++;
                if (sclk !== pol) begin
                    lead++;
                    if (!pha) begin
                        if (nsamp < W) mo_bits[nsamp] = mosi;
                        nsamp++;
                    end
                end else begin
                    trail++;
                    if (pha) begin
                        if (nsamp < W) mo_bits[nsamp] = mosi;
                        nsamp++;
                    end
                end
                prev = sclk;
            end
            // Slave: next bit after each trailing edge (cpha=0) or on each leading edge (cpha=1).
            idx = pha ? ((lead > 0) ? lead - 1 : 0) : trail;
            miso = lb ? mosi : ((idx < W) ? bit_of(slv, lsb, idx) : 1'b0);
            if (done === 1'b1) begin
                done_c = c;
                break;
            end
            if (ready !== 1'b0 || n_ss !== sel_mask(int'(sel))) busy_err++;
            if (busy_pulse) start = (c < d_exp - 1) && (c % 2 == 1);
        end
        if (!chain) start = 1'b0;
        for (int i = 0; i < W; i++) mo_exp[i] = bit_of(tx, lsb, i);
        rx_exp = lb ? tx : slv;
        $display("xfer %s tx=%h rx=%h want=%h done_at=%0d want=%0d edges=%0d",
                 name, tx, rx_word, rx_exp, done_c, d_exp, edges);
        n_checks++;
        if (done_c != d_exp) begin
            n_fail++;
            $display("FAIL %s done_time got=%0d want=%0d", name, done_c, d_exp);
        end
        n_checks++;
        if (edges != 2 * W) begin
            n_fail++;
            $display("FAIL %s sclk_edges got=%0d want=%0d", name, edges, 2 * W);
        end
        n_checks++;
        if (tim_err != 0) begin
            n_fail++;
            $display("FAIL %s edge_timing got=%0d misplaced want=0", name, tim_err);
        end
        n_checks++;
        if (mo_bits !== mo_exp) begin
            n_fail++;
            $display("FAIL %s mosi_bits got=%b want=%b", name, mo_bits, mo_exp);
        end
        n_checks++;
        if (rx_word !== rx_exp) begin
            n_fail++;
            $display("FAIL %s rx_word got=%h want=%h", name, rx_word, rx_exp);
        end
        n_checks++;
        if (busy_err != 0) begin
            n_fail++;
            $display("FAIL %s busy_window got=%0d bad cycles want=0", name, busy_err);
        end
        n_checks++;
        if (n_ss !== (hold ? sel_mask(int'(sel)) : {NSS{1'b1}}) || sclk !== pol || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_cycle got n_ss=%b sclk=%b ready=%b want n_ss=%b sclk=%b ready=1",
                     name, n_ss, sclk, ready, hold ? sel_mask(int'(sel)) : {NSS{1'b1}}, pol);
        end
        if (chain) begin
            tx_word = nx_tx; div = d; cpol = pol; cpha = pha; lsb_first = lsb;
            hold_ss = nx_hold; ss_sel = nx_sel; start = 1'b1;
        end else begin
            ext = busy_pulse ? d_exp : 3;
            extra_done = 0; extra_err = 0;
            for (int k = 0; k < ext; k++) begin
                @(negedge clk);
                if (done !== 1'b0) extra_done++;
                if (ready !== 1'b1 || rx_word !== rx_exp) extra_err++;
            end
            n_checks++;
            if (extra_done != 0 || extra_err != 0) begin
                n_fail++;
                $display("FAIL %s after_done got extra_done=%0d bad_idle=%0d want 0/0",
                         name, extra_done, extra_err);
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if (n_ss !== '1 || sclk !== 1'b0 || mosi !== 1'b0 || ready !== 1'b1 ||
            done !== 1'b0 || rx_word !== '0) begin
            n_fail++;
            $display("FAIL %s got n_ss=%b sclk=%b mosi=%b ready=%b done=%b rx=%h want 1111/0/0/1/0/00",
                     name, n_ss, sclk, mosi, ready, done, rx_word);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; hold_ss = 1'b0; ss_sel = '0; cpol = 1'b0;
        cpha = 1'b0; lsb_first = 1'b0; div = '0; tx_word = '0; miso = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset_async");
        repeat (3) @(negedge clk);
        check_reset_values("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset_release");
    endtask

    task automatic test_mode0();
        xfer("mode0_loop", 8'hA5, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mode3();
        xfer("mode3_div2", 8'h3C, 8'hC3, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_lsb_mode1();
        xfer("lsb_mode1", 8'h01, 8'h80, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        nx_tx = 8'h5E; nx_sel = 2'd2; nx_hold = 1'b0;
        xfer("b2b_same_a", 8'h96, 8'h69, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        xfer("b2b_same_b", 8'h5E, 8'h69, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        nx_tx = 8'hE7; nx_sel = 2'd1; nx_hold = 1'b0;
        xfer("b2b_swap_a", 8'h12, 8'hB4, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        xfer("b2b_swap_b", 8'hE7, 8'hB4, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_busy_start();
        xfer("busy_start", 8'hC9, 8'h2D, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_div_max();
        xfer("div_max", 8'h6B, 8'hD2, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            xfer($sformatf("rand%0d", n), W'($urandom), W'($urandom), DW'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, SW'($urandom),
                 1'($urandom), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int dcount;
        while (ready !== 1'b1) @(negedge clk);
        tx_word = 8'hFF; div = 4'd1; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0;
        hold_ss = 1'b1; ss_sel = 2'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_values("mid_reset_immediate");
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0) dcount++;
            if (k == 2) rst_n = 1'b1;
        end
        n_checks++;
        if (dcount != 0) begin
            n_fail++;
            $display("FAIL mid_reset_no_done got=%0d pulses want=0", dcount);
        end
        check_reset_values("mid_reset_after");
        xfer("after_reset", 8'h4D, 8'hB1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_lsb_mode1();
        test_back_to_back();
        test_busy_start();
        test_div_max();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
